mult_share_arbiter: RTL

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Two requesters share a single 4x4 unsigned multiplier. A round-robin
//   arbiter picks one requester in IDLE. Its operands are latched on the
//   accept edge and multiplied in CALC. The product is then held in RESP
//   until the consumer takes it.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req0_valid/req1_valid        requester has operands
//   req0_a/b, req1_a/b [3:0]     unsigned operands
//   req0_ready/req1_ready        operand accept (IDLE, winner only)
//   rsp_valid/rsp_ready          product handshake
//   rsp_data [7:0]               full 8-bit product
//   rsp_id                       requester that owns rsp_data
//   busy                         FSM not in IDLE
//   gnt_cnt0/gnt_cnt1 [CNT_W-1:0] accepted-request counters
//
// Build option
//   MULT_ARB_STATS_EN   when defined, builds the wrapping grant counters.
//                       When undefined, gnt_cnt0/gnt_cnt1 are tied to 0.

// 4x4 unsigned multiplier: carry-save (3:2 compressor) reduction of the four
// partial-product rows, followed by one carry-propagate add.
module hybrid_compressor_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] f
);

  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, c1, s2, c2;
  logic [6:0] maj1, maj2;

  always_comb begin
    pp0  = {4'b0000, a & {4{b[0]}}};
    pp1  = {3'b000, a & {4{b[1]}}, 1'b0};
    pp2  = {2'b00, a & {4{b[2]}}, 2'b00};
    pp3  = {1'b0, a & {4{b[3]}}, 3'b000};
    s1   = pp0 ^ pp1 ^ pp2;
    maj1 = (pp0[6:0] & pp1[6:0]) | (pp0[6:0] & pp2[6:0]) | (pp1[6:0] & pp2[6:0]);
    c1   = {maj1, 1'b0};
    s2   = s1 ^ c1 ^ pp3;
    maj2 = (s1[6:0] & c1[6:0]) | (s1[6:0] & pp3[6:0]) | (c1[6:0] & pp3[6:0]);
    c2   = {maj2, 1'b0};
    // The true product never exceeds 225, so dropping carries out of bit 7
    // does not change the result.
    f    = s2 + c2;
  end

endmodule

module mult_share_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, next_state;
  logic [3:0] op_a, op_b;
  logic       op_id;
  logic       last_gnt;
  logic       win_id;
  logic       accept;
  logic [7:0] product;

  hybrid_compressor_multiplier u_mult (
    .a (op_a),
    .b (op_b),
    .f (product)
  );

  // Arbitration and handshake. The ready outputs are gated by rst directly,
  // so they stay low during reset; accept itself does not depend on rst,
  // because the state registers are held in reset anyway.
  always_comb begin
    win_id = 1'b0;
    if (req0_valid && req1_valid) begin
      win_id = ~last_gnt;
    end else if (req1_valid) begin
      win_id = 1'b1;
    end

    accept     = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !win_id && !rst;
    req1_ready = accept &&  win_id && !rst;
    busy       = (state != IDLE);

    next_state = state;
    case (state)
      IDLE: if (accept)    next_state = CALC;
      CALC:                next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      last_gnt  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_a     <= win_id ? req1_a : req0_a;
        op_b     <= win_id ? req1_b : req0_b;
        op_id    <= win_id;
        last_gnt <= win_id;
      end
      if (state == CALC) begin
        rsp_data  <= product;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0, cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept) begin
      if (win_id) cnt1 <= cnt1 + 1'b1;
      else        cnt0 <= cnt0 + 1'b1;
    end
  end

  assign gnt_cnt0 = cnt0;
  assign gnt_cnt1 = cnt1;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule
